// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: a single-outstanding fetch engine feeding a
// DEPTH-entry circular FIFO of {pc, instruction} pairs for the decoder.
module prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stop,
  input  logic                       wb_pc,
  input  logic [XLEN-1:0]            wb_pc_data,
  output logic                       prog_mem_req,
  output logic [XLEN-1:0]            prog_mem_addr,
  input  logic                       prog_mem_ack,
  input  logic [31:0]                prog_mem_data,
  input  logic                       deq,
  output logic                       valid,
  output logic [31:0]                command,
  output logic [XLEN-1:0]            now_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = $clog2(DEPTH+1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  state_t          state, state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pend_pc;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  entry_t          mem [DEPTH];

  logic redirect, complete, hold, push, pop;

  // stop freezes the pipeline, so a redirect is only honoured while running.
  assign redirect      = wb_pc & ~stop;
  assign prog_mem_req  = ~reset & ((state != IDLE) | (~stop & (count < CW'(DEPTH))));
  assign prog_mem_addr = fetch_pc;
  assign complete      = prog_mem_req & prog_mem_ack;
  assign hold          = prog_mem_req & ~prog_mem_ack;
  assign push          = complete & (state != DISCARD) & ~redirect;
  assign pop           = deq & valid & ~stop & ~redirect;

  assign valid   = (count != '0);
  assign command = valid ? mem[rd_ptr].instr : NOP;
  assign now_pc  = valid ? mem[rd_ptr].pc : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A redirect while a request stays in flight cannot retarget the bus (the
  // address must hold until ack), so the request is parked in DISCARD.
  always_comb begin
    // NOTE: defaulting every always_comb output first rules out inferred latches.
    state_next = state;
    case (state)
      IDLE: begin
        if (hold) state_next = redirect ? DISCARD : WAIT;
      end
      WAIT: begin
        if (prog_mem_ack)  state_next = IDLE;
        else if (redirect) state_next = DISCARD;
      end
      DISCARD: begin
        if (prog_mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The redirect target waits in pend_pc until the abandoned request retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
    end else if (redirect && hold) begin
      pend_pc <= wb_pc_data;
    end else if (redirect) begin
      fetch_pc <= wb_pc_data;
    end else if (complete && state == DISCARD) begin
      fetch_pc <= pend_pc;
    end else if (push) begin
      fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: queue storage is not reset; count gates every read, so stale
  // contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: fetch_pc, instr: prog_mem_data};
  end

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, PC/address width; DEPTH, default 4, queue entries (power of 2, >=2); RESET_PC, default 0, fetch PC after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-004 stop  input  1  pipeline freeze.
REQ-005 wb_pc  input  1  redirect request (branch/jump/trap/hazard).
REQ-006 wb_pc_data  input  XLEN  redirect target PC.
REQ-007 prog_mem_req  output  1  instruction memory request.
REQ-008 prog_mem_addr  output  XLEN  request address.
REQ-009 prog_mem_ack  input  1  memory completes the current request this cycle.
REQ-010 prog_mem_data  input  32  instruction word; valid when prog_mem_ack=1.
REQ-011 deq  input  1  decode consumes head entry.
REQ-012 valid  output  1  head entry present.
REQ-013 command  output  32  head instruction.
REQ-014 now_pc  output  XLEN  PC of head instruction.
REQ-015 count  output  clog2(DEPTH+1)  occupied entries.

Function
REQ-016 Queue SHALL be a DEPTH-entry circular FIFO of {pc, instruction}; read/write pointers wrap modulo DEPTH.
REQ-017 Fetch FSM SHALL have states IDLE (nothing outstanding), WAIT (request outstanding), DISCARD (outstanding request whose data is dropped).
REQ-018 prog_mem_req SHALL be 1 in WAIT or DISCARD, and in IDLE when stop=0 and count<DEPTH; otherwise 0.
REQ-019 prog_mem_addr SHALL equal the fetch PC register and SHALL stay constant while prog_mem_req=1 until prog_mem_ack.
REQ-020 A transaction SHALL complete in any cycle where prog_mem_req=1 and prog_mem_ack=1, including the first cycle of the request (zero-wait memory).
REQ-021 At most one transaction SHALL be outstanding; zero-wait memory with deq every cycle SHALL sustain one instruction per cycle.
REQ-022 IDLE transitions: request without ack -> WAIT; request with ack -> IDLE.
REQ-023 WAIT transitions: ack -> IDLE; no ack with wb_pc=1 -> DISCARD; otherwise remain.
REQ-024 DISCARD transitions: ack -> IDLE with data dropped; otherwise remain.
REQ-025 A completing transaction SHALL push {prog_mem_addr, prog_mem_data} unless state is DISCARD or wb_pc=1 that cycle.
REQ-026 Each non-dropped completion SHALL advance the fetch PC by 4, modulo 2^XLEN.
REQ-027 On redirect the fetch PC SHALL load wb_pc_data.
REQ-028 On redirect the queue SHALL be flushed (count=0) in that same cycle.
REQ-029 Redirect SHALL take priority over deq and over push in the same cycle.
REQ-030 Pushed data SHALL be visible at valid/command/now_pc the cycle after completion; there is no bypass.
REQ-031 deq with valid=0 SHALL be ignored.
REQ-032 deq and push in the same cycle SHALL leave count unchanged.
REQ-033 Request gating (REQ-018) SHALL guarantee a push never occurs when count=DEPTH.
REQ-034 With stop=1: no new request issues from IDLE; deq and wb_pc are ignored; queue and fetch PC hold, except that an ack to an already-outstanding request is still accepted and pushed per REQ-025.
REQ-035 When valid=0, command SHALL be 32'h00000013 (NOP) and now_pc SHALL be 0.

Reset
REQ-036 On reset=1: fetch PC=RESET_PC, state=IDLE, pointers=0, count=0, valid=0, prog_mem_req=0, command=32'h00000013, now_pc=0.
REQ-037 Reset asserted mid-transaction SHALL abandon the transaction; any ack seen while reset=1 is ignored.

Verification
REQ-038 Reset release, RESET_PC=0, ack tied 1, deq=0 -> addresses 0,4,8,12 issued on consecutive cycles; count reaches 4; prog_mem_req=0 thereafter.
REQ-039 Ack tied 1, deq=1 every cycle -> one instruction per cycle; now_pc sequence 0,4,8,..., with no gaps after the first valid.
REQ-040 Ack held 0 for 3 cycles after request to addr 8, wb_pc=1 with target 0x100 in cycle 2 -> addr 8 held until ack, its data dropped, next request addr 0x100, queue empty until 0x100 arrives.
REQ-041 Queue full (count=4) with deq=1 and wb_pc=1 in the same cycle -> count=0 next cycle; next request addr = wb_pc_data.
REQ-042 stop=1 while a request is outstanding, ack arrives -> entry pushed; no further request while stop=1; deq ignored; count unchanged after the push.
REQ-043 Fetch PC at 0xFFFFFFFC with XLEN=32 -> next request addr 0x00000000.
